// File: rtl/mc_control_unit.sv
// mc_control_unit - multicycle control FSM for a shared-ALU / unified-memory datapath.
//
// Sequences one instruction over 3-5 cycles. A memory access waits for
// mem_ready for at most TIMEOUT cycles. After that, or on an illegal opcode,
// the unit enters a trap state that only rst can leave.
//
// Optional build macro: MC_INSTR_CNT_EN
//   defined   : instr_count counts retired instructions (wraps at 2^CNT_W)
//   undefined : instr_count is tied to 0 and no counter flops exist
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   opcode          IR[31:26]
//   zero            ALU zero flag (branch decision)
//   mem_ready       memory completes the current access this cycle
//   mem_req/mem_we/iord                   memory port control
//   ir_write/pc_en/pc_source              IR and PC control
//   alu_src_a/alu_src_b/alu_op            ALU operand and operation select
//   reg_dst/mem_to_reg/reg_write          register file control
//   trap            sticky fault flag
//   state           current state code (debug)
//   instr_count     retired instruction count
//
// state     | code | meaning
// ----------+------+-----------------------------------------------
// FETCH     |  0   | read instruction at PC, PC <= PC + 4
// DECODE    |  1   | decode opcode, branch target into ALUOut
// MEM_ADDR  |  2   | effective address regA + imm
// MEM_READ  |  3   | load data from memory into MDR
// MEM_WB    |  4   | write MDR to rt
// MEM_WRITE |  5   | store regB to memory
// EXEC      |  6   | R-type ALU operation
// R_WB      |  7   | write ALUOut to rd
// BRANCH    |  8   | compare, PC <= ALUOut when zero
// JUMP      |  9   | PC <= jump target
// ADDI_EX   | 10   | regA + imm
// ADDI_WB   | 11   | write ALUOut to rt
// TRAP      | 12   | fault, absorbing until rst

module mc_control_unit #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);

  // Wait timer is a down-counter: loaded with TIMEOUT-1, the wait cycle seen
  // at terminal count 0 is the TIMEOUT-th consecutive one.
  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       req_raw;
  logic       waiting;
  logic       wait_tc;

  assign req_raw = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);
  assign waiting = req_raw && !mem_ready;
  assign wait_tc = (wait_q == 8'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (wait_tc) state_d = S_TRAP;
      end
      S_DECODE: begin
        if      (opcode == OP_R)    state_d = S_EXEC;
        else if (opcode == OP_LW)   state_d = S_MEM_ADDR;
        else if (opcode == OP_SW)   state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ)  state_d = S_BRANCH;
        else if (opcode == OP_J)    state_d = S_JUMP;
        else if (opcode == OP_ADDI) state_d = S_ADDI_EX;
        else                        state_d = S_TRAP;
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (wait_tc) state_d = S_TRAP;
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (wait_tc) state_d = S_TRAP;
      end
      S_EXEC:      state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // Reload on ready or on any state change; a trapping timeout also reloads
  // because it changes state, so the counter never underflows.
  always_comb begin
    wait_d = WAIT_LOAD;
    if (waiting && (state_d == state_q)) wait_d = wait_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= WAIT_LOAD;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Control outputs decode from the registered state; only ir_write/pc_en in
  // FETCH and pc_en in BRANCH depend on live inputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    state      = state_q;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:  reg_write = 1'b1;
      S_TRAP:     trap = 1'b1;
      default:    trap = 1'b1;
    endcase
    // Reset cycle: nothing leaves the block, so an abandoned write never lands.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_source  = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      trap       = 1'b0;
      state      = 4'd0;
    end
  end

`ifdef MC_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // Every completing state returns to FETCH; TRAP entry never counts.
  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                   (state_q == S_R_WB)   || (state_q == S_BRANCH)    ||
                   (state_q == S_JUMP)   || (state_q == S_ADDI_WB));

  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count = rst ? '0 : cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  localparam int CNT_W = 32;
`ifdef MC_INSTR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {mem_req, mem_we, iord, ir_write, pc_en, pc_source[1:0], alu_src_a,
  //  alu_src_b[1:0], alu_op[1:0], reg_dst, mem_to_reg, reg_write, trap}
  localparam logic [15:0] C_ZERO    = 16'b0_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] C_FETCH_R = 16'b1_0_0_1_1_00_0_01_00_0_0_0_0;
  localparam logic [15:0] C_FETCH_W = 16'b1_0_0_0_0_00_0_01_00_0_0_0_0;
  localparam logic [15:0] C_DEC     = 16'b0_0_0_0_0_00_0_11_00_0_0_0_0;
  localparam logic [15:0] C_MADDR   = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [15:0] C_MREAD   = 16'b1_0_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] C_MWB     = 16'b0_0_0_0_0_00_0_00_00_0_1_1_0;
  localparam logic [15:0] C_MWR     = 16'b1_1_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] C_EXEC    = 16'b0_0_0_0_0_00_1_00_10_0_0_0_0;
  localparam logic [15:0] C_RWB     = 16'b0_0_0_0_0_00_0_00_00_1_0_1_0;
  localparam logic [15:0] C_BR_T    = 16'b0_0_0_0_1_01_1_00_01_0_0_0_0;
  localparam logic [15:0] C_BR_N    = 16'b0_0_0_0_0_01_1_00_01_0_0_0_0;
  localparam logic [15:0] C_JMP     = 16'b0_0_0_0_1_10_0_00_00_0_0_0_0;
  localparam logic [15:0] C_AEX     = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [15:0] C_AWB     = 16'b0_0_0_0_0_00_0_00_00_0_0_1_0;
  localparam logic [15:0] C_TRAP    = 16'b0_0_0_0_0_00_0_00_00_0_0_0_1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0]       pc_source;
  logic             alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             reg_dst, mem_to_reg, reg_write, trap;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic [15:0]      ctl_act;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.OP_W(6), .TIMEOUT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .trap(trap),
    .state(state), .instr_count(instr_count)
  );

  assign ctl_act = {mem_req, mem_we, iord, ir_write, pc_en, pc_source, alu_src_a,
                    alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, trap};

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    int          ret;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [3:0] st,
                     input logic [15:0] ctl, input int ret);
    vec_t v;
    v.r = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ret = ret;
    vq.push_back(v);
  endtask

  // One cycle: drive inputs after the falling edge, check just after.
  task automatic cyc(input logic r, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [3:0] est,
                     input logic [15:0] ectl, input int eret, input string nm);
    logic [CNT_W-1:0] ecnt;
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = rdy;
    #1;
    ecnt = CNT_EN ? CNT_W'(eret) : '0;
    n_assert++;
    if (state !== est) begin
      n_fail++;
      $display("FAIL %s state: got %0d want %0d", nm, state, est);
    end
    n_assert++;
    if (ctl_act !== ectl) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b want %b", nm, ctl_act, ectl);
    end
    n_assert++;
    if (instr_count !== ecnt) begin
      n_fail++;
      $display("FAIL %s instr_count: got %0d want %0d", nm, instr_count, ecnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, R, LW with 2 waits, SW, BEQ taken/not, J, ADDI, illegal opcode
    add(1, OP_R,    0, 0,  0, C_ZERO,    0);
    add(1, OP_R,    0, 1,  0, C_ZERO,    0);
    add(0, OP_R,    0, 1,  0, C_FETCH_R, 0);
    add(0, OP_R,    0, 1,  1, C_DEC,     0);
    add(0, OP_R,    0, 1,  6, C_EXEC,    0);
    add(0, OP_R,    0, 1,  7, C_RWB,     0);
    add(0, OP_LW,   0, 1,  0, C_FETCH_R, 1);
    add(0, OP_LW,   0, 1,  1, C_DEC,     1);
    add(0, OP_LW,   0, 1,  2, C_MADDR,   1);
    add(0, OP_LW,   0, 0,  3, C_MREAD,   1);
    add(0, OP_LW,   0, 0,  3, C_MREAD,   1);
    add(0, OP_LW,   0, 1,  3, C_MREAD,   1);
    add(0, OP_LW,   0, 1,  4, C_MWB,     1);
    add(0, OP_SW,   0, 1,  0, C_FETCH_R, 2);
    add(0, OP_SW,   0, 1,  1, C_DEC,     2);
    add(0, OP_SW,   0, 1,  2, C_MADDR,   2);
    add(0, OP_SW,   0, 1,  5, C_MWR,     2);
    add(0, OP_BEQ,  1, 1,  0, C_FETCH_R, 3);
    add(0, OP_BEQ,  1, 1,  1, C_DEC,     3);
    add(0, OP_BEQ,  1, 1,  8, C_BR_T,    3);
    add(0, OP_BEQ,  0, 1,  0, C_FETCH_R, 4);
    add(0, OP_BEQ,  0, 1,  1, C_DEC,     4);
    add(0, OP_BEQ,  0, 1,  8, C_BR_N,    4);
    add(0, OP_J,    0, 1,  0, C_FETCH_R, 5);
    add(0, OP_J,    0, 1,  1, C_DEC,     5);
    add(0, OP_J,    0, 1,  9, C_JMP,     5);
    add(0, OP_ADDI, 0, 1,  0, C_FETCH_R, 6);
    add(0, OP_ADDI, 0, 1,  1, C_DEC,     6);
    add(0, OP_ADDI, 0, 1, 10, C_AEX,     6);
    add(0, OP_ADDI, 0, 1, 11, C_AWB,     6);
    add(0, OP_BAD,  0, 0,  0, C_FETCH_W, 7);
    add(0, OP_BAD,  0, 0,  0, C_FETCH_W, 7);
    add(0, OP_BAD,  0, 1,  0, C_FETCH_R, 7);
    add(0, OP_BAD,  0, 1,  1, C_DEC,     7);
    add(0, OP_R,    1, 1, 12, C_TRAP,    7);

    for (int i = 0; i < vq.size(); i++)
      cyc(vq[i].r, vq[i].op, vq[i].z, vq[i].rdy, vq[i].st, vq[i].ctl, vq[i].ret,
          $sformatf("vec%0d", i));

    // trap absorbs any inputs
    for (int i = 0; i < 20; i++)
      cyc(0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 12, C_TRAP, 7, $sformatf("trap_hold%0d", i));
    cyc(1, OP_R, 0, 1, 0, C_ZERO, 0, "trap_rst");

    // fetch timeout after exactly 3 wait cycles
    cyc(0, OP_R, 0, 0, 0, C_FETCH_W, 0, "to_w1");
    cyc(0, OP_R, 0, 0, 0, C_FETCH_W, 0, "to_w2");
    cyc(0, OP_R, 0, 0, 0, C_FETCH_W, 0, "to_w3");
    cyc(0, OP_R, 0, 0, 12, C_TRAP, 0, "to_trap");
    cyc(1, OP_R, 0, 0, 0, C_ZERO, 0, "to_rst");

    // ready on the 3rd cycle wins; counter clears across states
    cyc(0, OP_LW, 0, 0, 0, C_FETCH_W, 0, "rw_w1");
    cyc(0, OP_LW, 0, 0, 0, C_FETCH_W, 0, "rw_w2");
    cyc(0, OP_LW, 0, 1, 0, C_FETCH_R, 0, "rw_ready");
    cyc(0, OP_LW, 0, 0, 1, C_DEC, 0, "rw_dec");
    cyc(0, OP_LW, 0, 0, 2, C_MADDR, 0, "rw_maddr");
    cyc(0, OP_LW, 0, 0, 3, C_MREAD, 0, "rw_mr1");
    cyc(0, OP_LW, 0, 0, 3, C_MREAD, 0, "rw_mr2");
    cyc(0, OP_LW, 0, 1, 3, C_MREAD, 0, "rw_mr3");
    cyc(0, OP_LW, 0, 0, 4, C_MWB, 0, "rw_mwb");

    // rst during a stalled store: no write leaves in the reset cycle
    cyc(0, OP_SW, 0, 1, 0, C_FETCH_R, 1, "sw_fetch");
    cyc(0, OP_SW, 0, 0, 1, C_DEC, 1, "sw_dec");
    cyc(0, OP_SW, 0, 0, 2, C_MADDR, 1, "sw_maddr");
    cyc(0, OP_SW, 0, 0, 5, C_MWR, 1, "sw_wait");
    cyc(1, OP_SW, 0, 0, 0, C_ZERO, 0, "sw_rst");
    cyc(0, OP_LW, 0, 0, 0, C_FETCH_W, 0, "sw_after");

    // memory read timeout
    cyc(0, OP_LW, 0, 1, 0, C_FETCH_R, 0, "mt_fetch");
    cyc(0, OP_LW, 0, 0, 1, C_DEC, 0, "mt_dec");
    cyc(0, OP_LW, 0, 0, 2, C_MADDR, 0, "mt_maddr");
    cyc(0, OP_LW, 0, 0, 3, C_MREAD, 0, "mt_w1");
    cyc(0, OP_LW, 0, 0, 3, C_MREAD, 0, "mt_w2");
    cyc(0, OP_LW, 0, 0, 3, C_MREAD, 0, "mt_w3");
    cyc(0, OP_LW, 0, 1, 12, C_TRAP, 0, "mt_trap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle successor to the single-cycle opcode decoder. A Moore/Mealy FSM sequences one instruction over 3-5 cycles, so the datapath shares one ALU and one unified memory.
- Adds a memory ready handshake with a bounded wait, and a sticky trap on illegal opcodes or memory timeout.
- Sits between the instruction register opcode field and the datapath muxes, register file, PC and memory port.

Parameters:
- OP_W, 6, opcode field width (inCode width).
- TIMEOUT, 15, maximum cycles mem_req may wait for mem_ready before trapping; legal range 1..255.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  OP_W  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access in this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write request (valid with mem_req).
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load enable.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = regA.
- alu_src_b  out  2  ALU B input: 00 = regB, 01 = PC increment constant, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded (to ALUControl).
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- trap  out  1  sticky fault flag.
- state  out  4  current state code, for debug.
- instr_count  out  CNT_W  retired instruction count.

Behaviour:
- Opcodes decoded: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000. Any other opcode is illegal.
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12.
- Reset:
  - An rst sample moves state to FETCH, clears the wait counter, trap and instr_count.
  - While rst is high, all outputs are forced to 0 combinationally and state reads 0.
  - rst mid-instruction abandons the instruction; no write is issued in the reset cycle.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_en equal mem_ready (Mealy).
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: R -> EXEC; LW/SW -> MEM_ADDR; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDI_EX; illegal -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_req=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero. Then FETCH.
- JUMP: pc_source=10, pc_en=1. Then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- Latency in cycles, with mem_ready high on the first request cycle: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each memory wait cycle adds 1.
- Wait counter:
  - Counts consecutive cycles in which mem_req=1 and mem_ready=0; it is cleared whenever mem_ready=1 or the state changes.
  - When the counter reaches TIMEOUT while mem_ready=0, the next state is TRAP.
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT completes the access normally (ready wins).
- TRAP:
  - All control outputs 0 and trap=1; absorbing until rst.
  - mem_ready and opcode are ignored.
- Any output not listed for a state is 0 in that state.
- mem_ready outside a request cycle is ignored.

Optional Feature:
- Macro: MC_INSTR_CNT_EN.
- With the macro defined:
  - instr_count increments by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB.
  - A branch retires whether taken or not.
  - Entering TRAP does not count.
- Without the macro: the port remains, is tied to 0, and no counter flops are inferred.

Test Plan:
- rst=1 for 2 cycles with opcode=000000 -> all outputs 0, state=0; first cycle after release shows FETCH with mem_req=1.
- R-type (opcode 000000), mem_ready=1 constantly -> states 0,1,6,7,0 on consecutive cycles; reg_write=1 and reg_dst=1 only in state 7; instr_count 0->1.
- LW (100011), mem_ready low for 2 cycles in MEM_READ -> sequence 0,1,2,3,3,3,4,0 (8 cycles); mem_to_reg=1 and reg_write=1 in state 4.
- BEQ (000100) with zero=1 -> pc_en=1 and pc_source=01 in state 8. Repeat with zero=0 -> pc_en=0; instr_count still increments.
- opcode=111111 in DECODE -> TRAP in the next cycle, trap=1 held for 20 cycles regardless of inputs; rst clears trap.
- TIMEOUT=3, mem_ready held 0 in FETCH -> 3 wait cycles, then TRAP. Rerun with mem_ready=1 on the 3rd wait cycle -> DECODE, no trap.
